memory_stage: RTL and testbench

Pipeline memory stage. It sits directly downstream of the ALU stage and consumes its buffered result, flags and destination register. It performs data-memory loads and stores, maintains the stack pointer for PUSH/POP/CALL/RET, and sequences the two-word INT and RTI stack frames. It returns saved flags and PC to the front of the pipe, stalling upstream for the extra cycle that INT and RTI need.

---
 rtl/memory_stage.sv | 158 +++++++++++++++
 tb/tb_memory_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Pipeline memory stage: data-memory loads/stores, stack pointer upkeep for PUSH/POP/CALL/RET,
// and the two-cycle INT/RTI stack-frame sequencer that returns saved flags and PC upstream.
module memory_stage #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        mem_op,
    input  logic [15:0]       alu_result,
    input  logic [15:0]       store_data,
    input  logic [15:0]       pc_plus1,
    input  logic [2:0]        flags_in,
    input  logic              wb_in,
    input  logic [2:0]        rdst_in,
    output logic [15:0]       mem_data_out,
    output logic [15:0]       alu_result_out,
    output logic              wb_out,
    output logic [2:0]        rdst_out,
    output logic [2:0]        flags_out,
    output logic              flags_restore,
    output logic [15:0]       pc_restore,
    output logic              pc_restore_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] sp_out
);

    typedef enum logic [1:0] {IDLE, INT2, RTI2} state_t;

    localparam logic [2:0] OP_NORM = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_INT  = 3'd5;
    localparam logic [2:0] OP_RTI  = 3'd6;

    logic [15:0] mem [0:(1<<ADDR_W)-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [2:0]        flag_hold_q, flag_hold_d;
    logic [15:0]       mem_data_q, alu_result_q, pc_restore_q;
    logic              wb_q, flags_restore_q, pc_valid_q;
    logic [2:0]        rdst_q, flags_q;

    logic [2:0]        op_eff;
    logic              wr_en, load_en, flags_en, pc_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [15:0]       wr_data;

    assign op_eff = (mem_op == 3'd7) ? OP_NORM : mem_op;
    assign stall  = (state_q == IDLE) && ((mem_op == OP_INT) || (mem_op == OP_RTI));

    // Decode one cycle's memory access, SP update and FSM step; INT2/RTI2 ignore mem_op.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        flag_hold_d = flag_hold_q;
        wr_en       = 1'b0;
        wr_addr     = sp_q;
        wr_data     = store_data;
        rd_addr     = sp_q + 1'b1;
        load_en     = 1'b0;
        flags_en    = 1'b0;
        pc_en       = 1'b0;
        case (state_q)
            INT2: begin
                wr_en   = 1'b1;
                wr_data = {13'b0, flag_hold_q};
                sp_d    = sp_q - 1'b1;
                state_d = IDLE;
            end
            RTI2: begin
                pc_en   = 1'b1;
                sp_d    = sp_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                case (op_eff)
                    OP_PUSH, OP_CALL: begin
                        wr_en   = 1'b1;
                        wr_data = (op_eff == OP_CALL) ? pc_plus1 : store_data;
                        sp_d    = sp_q - 1'b1;
                    end
                    OP_POP, OP_RET: begin
                        load_en = 1'b1;
                        pc_en   = (op_eff == OP_RET);
                        sp_d    = sp_q + 1'b1;
                    end
                    OP_INT: begin
                        wr_en       = 1'b1;
                        wr_data     = pc_plus1;
                        sp_d        = sp_q - 1'b1;
                        flag_hold_d = flags_in;
                        state_d     = INT2;
                    end
                    OP_RTI: begin
                        flags_en = 1'b1;
                        sp_d     = sp_q + 1'b1;
                        state_d  = RTI2;
                    end
                    default: begin
                        // A simultaneous store and load lets the store win and the load drop.
                        wr_addr = alu_result[ADDR_W-1:0];
                        rd_addr = alu_result[ADDR_W-1:0];
                        wr_en   = mem_write;
                        load_en = mem_read && !mem_write;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            sp_q            <= '1;
            flag_hold_q     <= '0;
            mem_data_q      <= '0;
            alu_result_q    <= '0;
            wb_q            <= 1'b0;
            rdst_q          <= '0;
            flags_q         <= '0;
            flags_restore_q <= 1'b0;
            pc_restore_q    <= '0;
            pc_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            sp_q            <= sp_d;
            flag_hold_q     <= flag_hold_d;
            alu_result_q    <= alu_result;
            wb_q            <= wb_in;
            rdst_q          <= rdst_in;
            flags_restore_q <= flags_en;
            pc_valid_q      <= pc_en;
            if (load_en)  mem_data_q   <= mem[rd_addr];
            if (flags_en) flags_q      <= mem[rd_addr][2:0];
            if (pc_en)    pc_restore_q <= mem[rd_addr];
        end
    end

    assign mem_data_out     = mem_data_q;
    assign alu_result_out   = alu_result_q;
    assign wb_out           = wb_q;
    assign rdst_out         = rdst_q;
    assign flags_out        = flags_q;
    assign flags_restore    = flags_restore_q;
    assign pc_restore       = pc_restore_q;
    assign pc_restore_valid = pc_valid_q;
    assign sp_out           = sp_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: read data is predicted into a scoreboard queue when a load-type
// op is driven and popped against mem_data_out after the request edge; SP, stall and pulses checked inline.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite, wbIn;
    logic [2:0]  memOp, flagsIn, rdstIn;
    logic [15:0] aluResult, storeData, pcPlus1;
    logic [15:0] memDataOut, aluResultOut, pcRestore;
    logic        wbOut, flagsRestore, pcRestoreValid, stall;
    logic [2:0]  rdstOut, flagsOut;
    logic [10:0] spOut;

    typedef struct {
        string       tag;
        logic [15:0] value;
    } expect_t;

    expect_t expQ[$];
    int      total = 0;
    int      bad   = 0;

    memory_stage #(.ADDR_W(11)) dut (
        .clk(clk), .rst(rst), .mem_read(memRead), .mem_write(memWrite), .mem_op(memOp),
        .alu_result(aluResult), .store_data(storeData), .pc_plus1(pcPlus1), .flags_in(flagsIn),
        .wb_in(wbIn), .rdst_in(rdstIn), .mem_data_out(memDataOut), .alu_result_out(aluResultOut),
        .wb_out(wbOut), .rdst_out(rdstOut), .flags_out(flagsOut), .flags_restore(flagsRestore),
        .pc_restore(pcRestore), .pc_restore_valid(pcRestoreValid), .stall(stall), .sp_out(spOut)
    );

    always #5 clk = ~clk;

    // Hard bound so a broken design can never hang the run.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic rd, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] data,
                                 input logic [15:0] pc, input logic [2:0] fl);
        memOp     = op;
        memRead   = rd;
        memWrite  = wr;
        aluResult = addr;
        storeData = data;
        pcPlus1   = pc;
        flagsIn   = fl;
        #1;
    endtask

    task automatic expectData(input string tag, input logic [15:0] value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic tick();
        expect_t e;
        @(posedge clk);
        #1;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.tag, memDataOut, e.value);
        end
    endtask

    initial begin
        rst    = 1'b1;
        wbIn   = 1'b0;
        rdstIn = 3'd0;
        applyStimulus(3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        #12;
        checkOutput("reset_sp", {5'b0, spOut}, 16'h07FF);
        checkOutput("reset_data", memDataOut, 16'h0000);
        checkOutput("reset_stall", {15'b0, stall}, 16'h0);
        checkOutput("reset_pcvalid", {15'b0, pcRestoreValid}, 16'h0);
        checkOutput("reset_flags", {13'b0, flagsOut}, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // store then load, with pass-through registers
        wbIn = 1'b1; rdstIn = 3'd5;
        applyStimulus(3'd0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0, 3'd0);
        tick();
        checkOutput("pass_alu", aluResultOut, 16'h0010);
        checkOutput("pass_wb", {15'b0, wbOut}, 16'h1);
        checkOutput("pass_rdst", {13'b0, rdstOut}, 16'h5);
        wbIn = 1'b0; rdstIn = 3'd2;
        applyStimulus(3'd0, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h0, 3'd0);
        expectData("load_beef", 16'hBEEF);
        tick();
        checkOutput("load_sp", {5'b0, spOut}, 16'h07FF);
        checkOutput("pass_wb0", {15'b0, wbOut}, 16'h0);
        applyStimulus(3'd0, 1'b1, 1'b1, 16'h0010, 16'h1111, 16'h0, 3'd0);
        expectData("rdwr_hold", 16'hBEEF);
        tick();
        applyStimulus(3'd7, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h0, 3'd0);
        expectData("op7_load", 16'h1111);
        tick();

        // PUSH, PUSH, POP, POP
        applyStimulus(3'd1, 1'b0, 1'b0, 16'h0, 16'h1234, 16'h0, 3'd0);
        tick();
        checkOutput("push1_sp", {5'b0, spOut}, 16'h07FE);
        applyStimulus(3'd1, 1'b1, 1'b1, 16'h0010, 16'h5678, 16'h0, 3'd0);
        tick();
        checkOutput("push2_sp", {5'b0, spOut}, 16'h07FD);
        applyStimulus(3'd2, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        expectData("pop1", 16'h5678);
        tick();
        checkOutput("pop1_sp", {5'b0, spOut}, 16'h07FE);
        applyStimulus(3'd2, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        expectData("pop2", 16'h1234);
        tick();
        checkOutput("pop2_sp", {5'b0, spOut}, 16'h07FF);

        // CALL then RET
        applyStimulus(3'd3, 1'b0, 1'b0, 16'h0, 16'h9999, 16'h0042, 3'd0);
        tick();
        checkOutput("call_sp", {5'b0, spOut}, 16'h07FE);
        applyStimulus(3'd4, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        expectData("ret_data", 16'h0042);
        tick();
        checkOutput("ret_pc", pcRestore, 16'h0042);
        checkOutput("ret_valid", {15'b0, pcRestoreValid}, 16'h1);
        checkOutput("ret_sp", {5'b0, spOut}, 16'h07FF);
        applyStimulus(3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        tick();
        checkOutput("ret_valid_drop", {15'b0, pcRestoreValid}, 16'h0);

        // INT then RTI
        applyStimulus(3'd5, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0100, 3'b101);
        checkOutput("int_stall", {15'b0, stall}, 16'h1);
        tick();
        checkOutput("int2_stall", {15'b0, stall}, 16'h0);
        checkOutput("int2_sp", {5'b0, spOut}, 16'h07FE);
        applyStimulus(3'd5, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0100, 3'b000);
        tick();
        checkOutput("int_done_sp", {5'b0, spOut}, 16'h07FD);
        applyStimulus(3'd6, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        checkOutput("rti_stall", {15'b0, stall}, 16'h1);
        tick();
        checkOutput("rti2_stall", {15'b0, stall}, 16'h0);
        checkOutput("rti_flags", {13'b0, flagsOut}, 16'h0005);
        checkOutput("rti_frestore", {15'b0, flagsRestore}, 16'h1);
        checkOutput("rti_pcvalid_early", {15'b0, pcRestoreValid}, 16'h0);
        checkOutput("rti2_sp", {5'b0, spOut}, 16'h07FE);
        tick();
        checkOutput("rti_frestore_drop", {15'b0, flagsRestore}, 16'h0);
        checkOutput("rti_pc", pcRestore, 16'h0100);
        checkOutput("rti_pcvalid", {15'b0, pcRestoreValid}, 16'h1);
        checkOutput("rti_sp", {5'b0, spOut}, 16'h07FF);
        applyStimulus(3'd0, 1'b1, 1'b0, 16'h07FE, 16'h0, 16'h0, 3'd0);
        expectData("int_flag_word", 16'h0005);
        tick();
        checkOutput("rti_pcvalid_drop", {15'b0, pcRestoreValid}, 16'h0);

        // SP wrap in both directions
        applyStimulus(3'd0, 1'b0, 1'b1, 16'h0000, 16'hCAFE, 16'h0, 3'd0);
        tick();
        applyStimulus(3'd2, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        expectData("wrap_pop", 16'hCAFE);
        tick();
        checkOutput("wrap_pop_sp", {5'b0, spOut}, 16'h0000);
        applyStimulus(3'd1, 1'b0, 1'b0, 16'h0, 16'hAAAA, 16'h0, 3'd0);
        tick();
        checkOutput("wrap_push_sp", {5'b0, spOut}, 16'h07FF);
        applyStimulus(3'd0, 1'b1, 1'b0, 16'h0000, 16'h0, 16'h0, 3'd0);
        expectData("wrap_push_word", 16'hAAAA);
        tick();

        // asynchronous reset in the middle of INT
        applyStimulus(3'd5, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0200, 3'b011);
        tick();
        checkOutput("int_mid_sp", {5'b0, spOut}, 16'h07FE);
        applyStimulus(3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        rst = 1'b1;
        #1;
        checkOutput("arst_sp", {5'b0, spOut}, 16'h07FF);
        checkOutput("arst_stall", {15'b0, stall}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(3'd0, 1'b1, 1'b0, 16'h07FF, 16'h0, 16'h0, 3'd0);
        expectData("arst_kept_pc", 16'h0200);
        tick();
        checkOutput("arst_idle_sp", {5'b0, spOut}, 16'h07FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
